// File: rtl/fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_scheduler
// Purpose  : Read-side burst scheduler for the clock-crossing FIFO, feeding
//            a 2-entry valid/ready output buffer. Define
//            FIFO_RD_SCHED_TIMEOUT_EN to enable the idle-timeout partial burst.
// Revision : 1.0
// ============================================================================
module fifo_read_scheduler #(
    parameter int DWIDTH    = 64,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DWIDTH-1:0] total_writes_sync,
    input  logic              total_writes_stable,
    input  logic              flush,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] total_reads,
    output logic [DWIDTH-1:0] occupancy,
    output logic              busy,
    output logic              err
);

    localparam int       C_DEPTH  = 2 ** ADDR_W;
    localparam int       C_BEAT_W = ADDR_W + 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic [DWIDTH-1:0]   r_wr_latched;
    logic [DWIDTH-1:0]   r_total_reads;
    logic [C_BEAT_W-1:0] r_beat;
    logic                r_inflight;
    logic                r_err;
    logic [DATA_W-1:0]   r_buf [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    logic [DWIDTH-1:0]   w_occ;
    logic                w_occ_neg;
    logic                w_occ_pos;
    logic                w_occ_ge_burst;
    logic                w_occ_one;
    logic                w_occ_over;
    logic                w_pop;
    logic [1:0]          w_slots;
    logic                w_issue;
    logic                w_timer_hit;

    assign w_occ          = r_wr_latched - r_total_reads;
    assign w_occ_neg      = w_occ[DWIDTH-1];
    assign w_occ_pos      = !w_occ_neg && (w_occ != '0);
    assign w_occ_ge_burst = !w_occ_neg && (w_occ >= DWIDTH'(BURST_LEN));
    assign w_occ_one      = (w_occ == DWIDTH'(1));
    assign w_occ_over     = !w_occ_neg && (w_occ > DWIDTH'(C_DEPTH));

    // A word leaving the buffer this cycle frees its slot for a new read,
    // which is what sustains one word per cycle under m_ready = 1.
    assign w_pop   = (r_count != 2'd0) && m_ready;
    assign w_slots = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    localparam int C_TIMER_W = $clog2(TIMEOUT + 1);
    logic [C_TIMER_W-1:0] r_timer;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_timer <= '0;
        end else if ((r_state == S_BURST) || !w_occ_pos) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timer_hit = (r_timer == C_TIMER_W'(TIMEOUT - 1));
`else
    assign w_timer_hit = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_occ_ge_burst || (w_occ_pos && (flush || w_timer_hit))) begin
                    w_next_state = S_BURST;
                end
            end
            S_BURST: begin
                if (!w_occ_pos) begin
                    w_next_state = S_IDLE;
                end else if (w_issue &&
                             ((r_beat == C_BEAT_W'(BURST_LEN - 1)) || w_occ_one)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        busy    = 1'b0;
        if (r_state == S_BURST) begin
            busy    = 1'b1;
            w_issue = (w_slots < 2'd2) && w_occ_pos;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_latched  <= '0;
            r_total_reads <= '0;
            r_beat        <= '0;
            r_inflight    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (total_writes_stable) begin
                r_wr_latched <= total_writes_sync;
            end
            if (w_issue) begin
                r_total_reads <= r_total_reads + 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_beat <= '0;
            end else if (w_issue) begin
                r_beat <= r_beat + 1'b1;
            end
            r_inflight <= w_issue;
            r_err      <= r_err | w_occ_neg | w_occ_over;
        end
    end

    // RAM data lands one cycle after its strobe, tracked by r_inflight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= ram_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_slots;
        end
    end

    assign ram_rd_en   = w_issue;
    assign ram_rd_addr = r_total_reads[ADDR_W-1:0];
    assign m_data      = r_buf[r_rd_ptr];
    assign m_valid     = (r_count != 2'd0);
    assign total_reads = r_total_reads;
    assign occupancy   = w_occ;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_scheduler
// Purpose  : Self-checking bench for fifo_read_scheduler with a RAM model and
//            read/pop logs compared against spec-derived expectations.
// Revision : 1.0
// ============================================================================
module tb_fifo_read_scheduler;

    localparam int DWIDTH    = 64;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              aclk = 1'b0;
    logic              areset;
    logic [DWIDTH-1:0] total_writes_sync;
    logic              total_writes_stable;
    logic              flush;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] total_reads;
    logic [DWIDTH-1:0] occupancy;
    logic              busy;
    logic              err;

    fifo_read_scheduler #(
        .DWIDTH    (DWIDTH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .total_writes_sync   (total_writes_sync),
        .total_writes_stable (total_writes_stable),
        .flush               (flush),
        .ram_rd_en           (ram_rd_en),
        .ram_rd_addr         (ram_rd_addr),
        .ram_rd_data         (ram_rd_data),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .total_reads         (total_reads),
        .occupancy           (occupancy),
        .busy                (busy),
        .err                 (err)
    );

    always #5 aclk = ~aclk;

    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge aclk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    logic [ADDR_W-1:0] addr_log [$];
    logic [DATA_W-1:0] pop_log  [$];
    int n_vec = 0;
    int n_err = 0;

    // Records reads and accepted words at the negedge, returns just after the posedge.
    task automatic tick();
        @(negedge aclk);
        if (!areset) begin
            if (ram_rd_en) addr_log.push_back(ram_rd_addr);
            if (m_valid && m_ready) pop_log.push_back(m_data);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        total_writes_sync = '0;
        total_writes_stable = 1'b1;
        flush = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        addr_log.delete();
        pop_log.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        total_writes_sync = '0;
        total_writes_stable = 1'b1;
        flush = 1'b0;
        m_ready = 1'b1;
        tick();
        n_vec++; if (ram_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", ram_rd_en); end
        n_vec++; if (ram_rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr: got %0h expected 0", ram_rd_addr); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        n_vec++; if (total_reads !== '0) begin n_err++; $display("FAIL reset_total_reads: got %0d expected 0", total_reads); end
        n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
        areset = 1'b0;
    endtask

    task automatic test_burst();
        do_reset();
        total_writes_sync = DWIDTH'(4);
        tick();
        n_vec++; if (occupancy !== DWIDTH'(4)) begin n_err++; $display("FAIL burst_occ: got %0d expected 4", occupancy); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_early: got %b expected 0", busy); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (busy !== 1'b1 || ram_rd_en !== 1'b1 || ram_rd_addr !== ADDR_W'(i)) begin
                n_err++;
                $display("FAIL burst_beat%0d: got busy=%b en=%b addr=%0d expected busy=1 en=1 addr=%0d",
                         i, busy, ram_rd_en, ram_rd_addr, i);
            end
            tick();
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_fall: got %b expected 0", busy); end
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (total_reads !== DWIDTH'(4)) begin n_err++; $display("FAIL burst_total: got %0d expected 4", total_reads); end
        n_vec++; if (pop_log.size() != 4) begin n_err++; $display("FAIL burst_pops: got %0d expected 4", pop_log.size()); end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_vec++;
            if (pop_log[i] !== mem[i % DEPTH]) begin
                n_err++; $display("FAIL burst_data%0d: got %0h expected %0h", i, pop_log[i], mem[i % DEPTH]);
            end
        end
    endtask

    task automatic test_partial();
        int first;
        do_reset();
        total_writes_sync = DWIDTH'(2);
        tick();
        first = -1;
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            if (ram_rd_en && first < 0) first = i;
            tick();
        end
        n_vec++; if (first != TIMEOUT) begin n_err++; $display("FAIL timeout_first_read: got cycle %0d expected %0d", first, TIMEOUT); end
`else
        for (int i = 0; i < 40; i++) tick();
        n_vec++; if (addr_log.size() != 0) begin n_err++; $display("FAIL noflush_reads: got %0d expected 0", addr_log.size()); end
        flush = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ram_rd_en && first < 0) first = i;
            tick();
        end
        n_vec++; if (first != 1) begin n_err++; $display("FAIL flush_first_read: got cycle %0d expected 1", first); end
`endif
        n_vec++; if (addr_log.size() != 2) begin n_err++; $display("FAIL partial_reads: got %0d expected 2", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            n_vec++;
            if (addr_log[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL partial_addr%0d: got %0d expected %0d", i, addr_log[i], i); end
        end
        flush = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (addr_log.size() != 2 || busy !== 1'b0) begin
            n_err++; $display("FAIL flush_empty: got reads=%0d busy=%b expected reads=2 busy=0", addr_log.size(), busy);
        end
        n_vec++;
        if (pop_log.size() != 2 || pop_log[0] !== mem[0] || pop_log[1] !== mem[1]) begin
            n_err++; $display("FAIL partial_data: got %0d words expected 2 matching RAM", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        int t;
        do_reset();
        m_ready = 1'b0;
        total_writes_sync = DWIDTH'(8);
        for (int i = 0; i < 20; i++) tick();
        n_vec++; if (addr_log.size() != 2) begin n_err++; $display("FAIL bp_reads: got %0d expected 2", addr_log.size()); end
        n_vec++; if (ram_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b expected 0", ram_rd_en); end
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== mem[0]) begin
            n_err++; $display("FAIL bp_head: got valid=%b data=%0h expected valid=1 data=%0h", m_valid, m_data, mem[0]);
        end
        m_ready = 1'b1;
        t = 0;
        while (pop_log.size() < 8 && t < 60) begin tick(); t++; end
        n_vec++; if (pop_log.size() != 8) begin n_err++; $display("FAIL bp_drain: got %0d words expected 8", pop_log.size()); end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_vec++;
            if (pop_log[i] !== mem[i % DEPTH]) begin n_err++; $display("FAIL bp_data%0d: got %0h expected %0h", i, pop_log[i], mem[i % DEPTH]); end
        end
        n_vec++; if (total_reads !== DWIDTH'(8)) begin n_err++; $display("FAIL bp_total: got %0d expected 8", total_reads); end
    endtask

    task automatic test_stable();
        int t;
        do_reset();
        m_ready = 1'b0;
        total_writes_sync = DWIDTH'(4);
        tick();
        tick();
        total_writes_stable = 1'b0;
        total_writes_sync = DWIDTH'(9);
        for (int i = 0; i < 10; i++) tick();
        n_vec++;
        if (occupancy !== DWIDTH'(4 - addr_log.size())) begin
            n_err++; $display("FAIL stable_hold: got %0d expected %0d", occupancy, 4 - addr_log.size());
        end
        total_writes_stable = 1'b1;
        tick();
        n_vec++;
        if (occupancy !== DWIDTH'(9 - addr_log.size())) begin
            n_err++; $display("FAIL stable_update: got %0d expected %0d", occupancy, 9 - addr_log.size());
        end
        m_ready = 1'b1;
        flush = 1'b1;
        t = 0;
        while (pop_log.size() < 9 && t < 80) begin tick(); t++; end
        n_vec++; if (total_reads !== DWIDTH'(9)) begin n_err++; $display("FAIL stable_total: got %0d expected 9", total_reads); end
        n_vec++; if (pop_log.size() != 9) begin n_err++; $display("FAIL stable_pops: got %0d expected 9", pop_log.size()); end
    endtask

    task automatic test_wrap();
        int t;
        do_reset();
        flush = 1'b1;
        total_writes_sync = DWIDTH'(10);
        t = 0;
        while (pop_log.size() < 10 && t < 60) begin tick(); t++; end
        total_writes_sync = DWIDTH'(20);
        t = 0;
        while (pop_log.size() < 20 && t < 80) begin tick(); t++; end
        n_vec++; if (total_reads !== DWIDTH'(20)) begin n_err++; $display("FAIL wrap_total: got %0d expected 20", total_reads); end
        n_vec++; if (addr_log.size() != 20) begin n_err++; $display("FAIL wrap_reads: got %0d expected 20", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            n_vec++;
            if (addr_log[i] !== ADDR_W'(i % DEPTH)) begin n_err++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addr_log[i], i % DEPTH); end
        end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_vec++;
            if (pop_log[i] !== mem[i % DEPTH]) begin n_err++; $display("FAIL wrap_data%0d: got %0h expected %0h", i, pop_log[i], mem[i % DEPTH]); end
        end
    endtask

    task automatic test_err_reset();
        int t;
        do_reset();
        total_writes_sync = DWIDTH'(DEPTH + 1);
        tick();
        tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", err); end
        for (int i = 0; i < 10; i++) tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err); end
        t = 0;
        while (!(busy && ram_rd_en) && t < 20) begin tick(); t++; end
        n_vec++; if (t >= 20) begin n_err++; $display("FAIL err_burst_wait: got no burst expected busy within 20 cycles"); end
        areset = 1'b1;
        total_writes_sync = '0;
        tick();
        n_vec++;
        if (ram_rd_en !== 1'b0 || ram_rd_addr !== '0 || m_valid !== 1'b0 || m_data !== '0 ||
            total_reads !== '0 || occupancy !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL midburst_reset: got en=%b addr=%0d v=%b d=%0h rd=%0d occ=%0d busy=%b err=%b expected all 0",
                     ram_rd_en, ram_rd_addr, m_valid, m_data, total_reads, occupancy, busy, err);
        end
        areset = 1'b0;
        tick();
        tick();
        n_vec++;
        if (m_valid !== 1'b0 || occupancy !== '0) begin
            n_err++; $display("FAIL midburst_discard: got valid=%b occ=%0d expected valid=0 occ=0", m_valid, occupancy);
        end
    endtask

    task automatic test_random();
        int wr_cnt;
        int t;
        do_reset();
        wr_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            m_ready = ($urandom_range(3) != 0);
            total_writes_stable = ($urandom_range(3) != 0);
            flush = ($urandom_range(15) == 0);
            if (wr_cnt - pop_log.size() <= 11) wr_cnt += $urandom_range(3);
            total_writes_sync = DWIDTH'(wr_cnt);
            tick();
            n_vec++;
            if (addr_log.size() - pop_log.size() > 2 || total_reads > DWIDTH'(wr_cnt)) begin
                n_err++;
                $display("FAIL rand_outstanding: got reads=%0d pops=%0d total=%0d expected reads-pops<=2 total<=%0d",
                         addr_log.size(), pop_log.size(), total_reads, wr_cnt);
            end
        end
        total_writes_stable = 1'b1;
        flush = 1'b1;
        m_ready = 1'b1;
        t = 0;
        while (pop_log.size() < wr_cnt && t < 200) begin tick(); t++; end
        n_vec++; if (total_reads !== DWIDTH'(wr_cnt)) begin n_err++; $display("FAIL rand_total: got %0d expected %0d", total_reads, wr_cnt); end
        n_vec++; if (pop_log.size() != wr_cnt) begin n_err++; $display("FAIL rand_pops: got %0d expected %0d", pop_log.size(), wr_cnt); end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_vec++;
            if (pop_log[i] !== mem[i % DEPTH]) begin n_err++; $display("FAIL rand_data%0d: got %0h expected %0h", i, pop_log[i], mem[i % DEPTH]); end
        end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = ($urandom & 32'h00FF_FFFF) | (i << 24);
        end
        areset = 1'b1;
        total_writes_sync = '0;
        total_writes_stable = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_burst();
        test_partial();
        test_backpressure();
        test_stable();
        test_wrap();
        test_err_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
